// File: rtl/apb_wait_slave.sv
// APB register-file slave: DEPTH words of DATA_W bits, fixed WAIT_CYCLES wait states per access,
// PSLVERR for addresses at or beyond DEPTH.
module apb_wait_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_C  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   addr_r;
    logic               write_r;
    logic               err_r;
    logic [3:0]         cnt_r, cnt_s;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    logic               err_in_s;
    logic               ready_s;
    logic               slverr_s;
    logic               latch_s;
    logic               load_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   rd_addr_s;
    logic               rd_skip_s;
    logic [DATA_W-1:0]  rdata_s;

    assign err_in_s = ({1'b0, PADDR} >= DEPTH_C);

    // Response data comes from the live bus on a zero-wait setup, otherwise from the latched transfer.
    always_comb begin
        rd_addr_s = addr_r;
        rd_skip_s = write_r | err_r;
        if (state_r == ST_IDLE) begin
            rd_addr_s = PADDR[IDX_W-1:0];
            rd_skip_s = PWRITE | err_in_s;
        end else begin
            rd_addr_s = addr_r;
            rd_skip_s = write_r | err_r;
        end
        rdata_s = rd_skip_s ? {DATA_W{1'b0}} : mem_r[rd_addr_s];
    end

    // Next-state and response decisions for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ready_s  = PREADY;
        slverr_s = PSLVERR;
        latch_s  = 1'b0;
        load_s   = 1'b0;
        wr_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch_s = 1'b1;
                    cnt_s   = WAIT_C;
                    if (WAIT_C == 4'd0) begin
                        state_s  = ST_RESP;
                        ready_s  = 1'b1;
                        slverr_s = err_in_s;
                        load_s   = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_s  = ST_IDLE;
                    ready_s  = 1'b0;
                    slverr_s = 1'b0;
                end else if (PENABLE) begin
                    cnt_s = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_s  = ST_RESP;
                        ready_s  = 1'b1;
                        slverr_s = err_r;
                        load_s   = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (!PSEL) begin
                    state_s  = ST_IDLE;
                    ready_s  = 1'b0;
                    slverr_s = 1'b0;
                end else if (PENABLE) begin
                    wr_en_s  = write_r & ~err_r;
                    state_s  = ST_IDLE;
                    ready_s  = 1'b0;
                    slverr_s = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                ready_s  = 1'b0;
                slverr_s = 1'b0;
            end
        endcase
    end

    // Control state, latched transfer attributes and registered bus outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            write_r <= 1'b0;
            err_r   <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            PREADY  <= ready_s;
            PSLVERR <= slverr_s;
            if (latch_s) begin
                addr_r  <= PADDR[IDX_W-1:0];
                write_r <= PWRITE;
                err_r   <= err_in_s;
            end
            if (load_s) begin
                PRDATA <= rdata_s;
            end
        end
    end

    // Storage array; writes commit only on the completion edge of a legal write.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[addr_r] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: three instances (1, 0 and 3 wait states) on private buses,
// directed vector table, corner-case sequences and a random run against a memory-array model.
module tb_apb_wait_slave;

    logic       clk;
    logic       rstn;
    logic [2:0] psel;
    logic [2:0] penable;
    logic [2:0] pwrite;
    logic [7:0] paddr  [3];
    logic [7:0] pwdata [3];
    logic [2:0] pready;
    logic [7:0] prdata [3];
    logic [2:0] pslverr;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [3][64];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_wait_slave #(
            .ADDR_W(8), .DATA_W(8), .DEPTH(64),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .PCLK(clk), .PRESETn(rstn), .PSEL(psel[g]), .PENABLE(penable[g]),
            .PWRITE(pwrite[g]), .PADDR(paddr[g]), .PWDATA(pwdata[g]),
            .PREADY(pready[g]), .PRDATA(prdata[g]), .PSLVERR(pslverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One complete transfer; also checks PREADY falls right after completion.
    task automatic xfer(input int idx, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output int waits);
        psel[idx] = 1'b1; penable[idx] = 1'b0; pwrite[idx] = wr;
        paddr[idx] = a; pwdata[idx] = wd;
        tick();
        penable[idx] = 1'b1;
        waits = 0;
        while (!pready[idx] && waits < 40) begin
            waits++;
            tick();
        end
        check($sformatf("ready_seen[%0d]", idx), {31'd0, pready[idx]}, 32'd1);
        rd = prdata[idx];
        er = pslverr[idx];
        tick();
        check($sformatf("ready_drop[%0d]", idx), {31'd0, pready[idx]}, 32'd0);
        psel[idx] = 1'b0; penable[idx] = 1'b0;
    endtask

    // Model-driven transfer: expectations come from ref_mem and the address rule.
    task automatic model_xfer(input int idx, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] rd;
        logic       er;
        int         waits;
        bit         exp_err;
        logic [7:0] exp_rd;
        exp_err = (a >= 8'd64);
        exp_rd  = (wr || exp_err) ? 8'h00 : ref_mem[idx][a[5:0]];
        xfer(idx, wr, a, wd, rd, er, waits);
        check($sformatf("m_rdata[%0d]@%0h", idx, a), {24'd0, rd}, {24'd0, exp_rd});
        check($sformatf("m_err[%0d]@%0h", idx, a), {31'd0, er}, {31'd0, exp_err});
        check($sformatf("m_waits[%0d]", idx), waits, wc(idx));
        if (wr && !exp_err) ref_mem[idx][a[5:0]] = wd;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         waits;

        vecs[0]  = '{1'b0, 8'd5,   8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'd60,  8'hD9, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'd60,  8'h00, 8'hD9, 1'b0};
        vecs[3]  = '{1'b1, 8'd54,  8'h9D, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'd54,  8'h00, 8'h9D, 1'b0};
        vecs[5]  = '{1'b0, 8'd60,  8'h00, 8'hD9, 1'b0};
        vecs[6]  = '{1'b1, 8'hDE,  8'h09, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 8'hDE,  8'h00, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 8'd60,  8'h00, 8'hD9, 1'b0};
        vecs[9]  = '{1'b1, 8'd63,  8'h5A, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'd63,  8'h00, 8'h5A, 1'b0};
        vecs[11] = '{1'b0, 8'd64,  8'h00, 8'h00, 1'b1};
        vecs[12] = '{1'b1, 8'd64,  8'h77, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 8'd63,  8'h00, 8'h5A, 1'b0};
        vecs[14] = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 8'h80,  8'h00, 8'h00, 1'b1};

        psel = 3'b000; penable = 3'b000; pwrite = 3'b000;
        for (int i = 0; i < 3; i++) begin
            paddr[i] = 8'h00; pwdata[i] = 8'h00;
            for (int j = 0; j < 64; j++) ref_mem[i][j] = 8'h00;
        end

        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready[%0d]", i), {31'd0, pready[i]}, 32'd0);
            check($sformatf("rst_err[%0d]", i), {31'd0, pslverr[i]}, 32'd0);
            check($sformatf("rst_rdata[%0d]", i), {24'd0, prdata[i]}, 32'd0);
        end

        // Directed table on the one-wait-state instance, back to back.
        for (int v = 0; v < 16; v++) begin
            xfer(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, er, waits);
            check($sformatf("vec%0d_rdata", v), {24'd0, rd}, {24'd0, vecs[v].exp_rdata});
            check($sformatf("vec%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
            check($sformatf("vec%0d_waits", v), waits, 32'd1);
            if (vecs[v].wr && !vecs[v].exp_err) ref_mem[0][vecs[v].addr[5:0]] = vecs[v].wdata;
        end

        // Abort during WAIT: write 0xFF@12 never completes.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd12; pwdata[0] = 8'hFF;
        tick();
        penable[0] = 1'b1;
        check("abort_wait_low", {31'd0, pready[0]}, 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort_ready_%0d", k), {31'd0, pready[0]}, 32'd0);
        end
        model_xfer(0, 1'b0, 8'd12, 8'h00);

        // Abort in RESP on the three-wait instance: no write may land.
        model_xfer(2, 1'b1, 8'd7, 8'h44);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd7; pwdata[2] = 8'h33;
        tick();
        penable[2] = 1'b1;
        for (int k = 0; k < 10 && !pready[2]; k++) tick();
        check("resp_abort_ready_up", {31'd0, pready[2]}, 32'd1);
        psel[2] = 1'b0; penable[2] = 1'b0;
        tick();
        check("resp_abort_ready_drop", {31'd0, pready[2]}, 32'd0);
        model_xfer(2, 1'b0, 8'd7, 8'h00);

        // Randomised traffic on every instance, including out-of-range addresses.
        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = n % 3;
            model_xfer(idx, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int idx = 0; idx < 3; idx++) begin
            model_xfer(idx, 1'b1, 8'd3, 8'hA5);
            model_xfer(idx, 1'b0, 8'd3, 8'h00);
        end

        // Reset in the middle of a WAIT: PREADY stays low and memory is cleared.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd4; pwdata[2] = 8'h11;
        tick();
        penable[2] = 1'b1;
        tick();
        check("midwait_low", {31'd0, pready[2]}, 32'd0);
        rstn = 1'b0;
        tick();
        check("rst_midwait_ready", {31'd0, pready[2]}, 32'd0);
        rstn = 1'b1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 64; j++) ref_mem[i][j] = 8'h00;
        tick();
        model_xfer(2, 1'b0, 8'd3, 8'h00);
        model_xfer(2, 1'b0, 8'd4, 8'h00);
        model_xfer(0, 1'b0, 8'd60, 8'h00);
        model_xfer(1, 1'b0, 8'd3, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
